// File: rtl/jpeg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_ctrl_pkg
// Shared types and constants for the JPEG control-path schedulers. These are the
// DCT block scheduler, and later the quantiser and Huffman schedulers.
//   sched_state_t   : scheduler FSM state encoding
//   SRC_Y/CB/CR     : requester indices on the packed source buses
//   *_DEF           : default block geometry and timing
//   sched_cnt_w()   : width of a counter that must reach both limits
// -----------------------------------------------------------------------------
package jpeg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    CLR,
    FEED,
    FLUSH,
    WAIT,
    DONE,
    ERR
  } sched_state_t;

  localparam int SRC_Y  = 0;
  localparam int SRC_CB = 1;
  localparam int SRC_CR = 2;

  localparam int PIX_PER_BLK_DEF = 64;
  localparam int FLUSH_CYC_DEF   = 2;
  localparam int CLR_CYC_DEF     = 2;
  localparam int TIMEOUT_DEF     = 1000;

  // One counter is shared by the CLR, FEED, FLUSH and WAIT phases. It must
  // therefore span the larger of the block length and the timeout.
  function automatic int sched_cnt_w(input int pix, input int tmo);
    int m;
    m = (pix > tmo) ? pix : tmo;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/dct_block_scheduler_if.sv
// -----------------------------------------------------------------------------
// dct_block_scheduler_if
// Bundle between the block buffers, the shared DCT engine and the scheduler.
//   src_req/src_data/src_ready     : block-buffer side (one lane per source)
//   blk_done/blk_err               : per-source completion pulses
//   dct_rst/dct_enable/dct_data_in : engine control and pixel stream
//   dct_output_enable              : engine result-valid flag
//   busy/grant_id                  : status
// Modport master = scheduler, slave = surrounding environment.
// -----------------------------------------------------------------------------
interface dct_block_scheduler_if #(
  parameter int NUM_SRC = 3,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0]   src_req;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_ready;
  logic [NUM_SRC-1:0]   blk_done;
  logic [NUM_SRC-1:0]   blk_err;
  logic                 dct_rst;
  logic                 dct_enable;
  logic [7:0]           dct_data_in;
  logic                 dct_output_enable;
  logic                 busy;
  logic [IDX_W-1:0]     grant_id;

  modport master (
    input  src_req, src_data, dct_output_enable,
    output src_ready, blk_done, blk_err, dct_rst, dct_enable, dct_data_in,
           busy, grant_id
  );

  modport slave (
    output src_req, src_data, dct_output_enable,
    input  src_ready, blk_done, blk_err, dct_rst, dct_enable, dct_data_in,
           busy, grant_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at the index just after
// last_grant and wraps around.
//   req        in  N      request vector
//   last_grant in  IDX_W  index of the previous winner
//   gnt_oh     out N      one-hot winner (all zero if no request)
//   gnt_idx    out IDX_W  winner index (0 if no request)
//   gnt_vld    out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int k;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = 0;
    // i = N revisits last_grant itself. A lone requester can therefore win
    // again, but only after every other index has been checked.
    for (int i = 1; i <= N; i++) begin
      k = int'(last_grant) + i;
      if (k >= N) k = k - N;
      if (!gnt_vld && req[IDX_W'(k)]) begin
        gnt_vld             = 1'b1;
        gnt_oh[IDX_W'(k)]   = 1'b1;
        gnt_idx             = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/dct_block_scheduler.sv
// -----------------------------------------------------------------------------
// dct_block_scheduler
// Time-shares one 8x8 DCT engine among NUM_SRC block buffers (Y, Cb, Cr).
// Owners are picked round-robin, one 64-pixel block at a time. For each block:
//   ARB   pick the owner
//   CLR   hold the engine reset for CLR_CYC cycles
//   FEED  stream PIX_PER_BLK pixels
//   FLUSH keep enable high for FLUSH_CYC more cycles
//   WAIT  wait for the result flag, up to TIMEOUT cycles
//   DONE/ERR pulse to the owner
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    master side of dct_block_scheduler_if (see interface header)
// -----------------------------------------------------------------------------
module dct_block_scheduler
  import jpeg_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int PIX_PER_BLK = PIX_PER_BLK_DEF,
  parameter int FLUSH_CYC   = FLUSH_CYC_DEF,
  parameter int CLR_CYC     = CLR_CYC_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dct_block_scheduler_if.master  bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = sched_cnt_w(PIX_PER_BLK, TIMEOUT);

  sched_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_id;
  logic [NUM_SRC-1:0] grant_oh;
  logic [NUM_SRC-1:0] src_ready;
  logic [NUM_SRC-1:0] blk_done;
  logic [NUM_SRC-1:0] blk_err;
  logic               dct_rst;
  logic               dct_enable;
  logic               busy;

  logic [NUM_SRC-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [7:0]         pix [NUM_SRC];

  rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_arb (
    .req        (bus.src_req),
    .last_grant (last_grant),
    .gnt_oh     (arb_oh),
    .gnt_idx    (arb_idx),
    .gnt_vld    (arb_vld)
  );

  // Outputs are registered on the transition into each state. They therefore
  // line up exactly with the state register. The engine reset register powers
  // up high and drops on the first clock after rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
      grant_id   <= '0;
      grant_oh   <= '0;
      src_ready  <= '0;
      blk_done   <= '0;
      blk_err    <= '0;
      dct_rst    <= 1'b1;
      dct_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      blk_done <= '0;
      blk_err  <= '0;
      case (state)
        IDLE: begin
          dct_rst <= 1'b0;
          if (|bus.src_req) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (arb_vld) begin
            state    <= CLR;
            grant_id <= arb_idx;
            grant_oh <= arb_oh;
            cnt      <= '0;
            dct_rst  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CLR: begin
          if (cnt == CNT_W'(CLR_CYC - 1)) begin
            state      <= FEED;
            cnt        <= '0;
            dct_rst    <= 1'b0;
            dct_enable <= 1'b1;
            src_ready  <= grant_oh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FEED: begin
          if (cnt == CNT_W'(PIX_PER_BLK - 1)) begin
            state     <= FLUSH;
            cnt       <= '0;
            src_ready <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == CNT_W'(FLUSH_CYC - 1)) begin
            state      <= WAIT;
            cnt        <= '0;
            dct_enable <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          // The result flag is checked first, so a flag on the last allowed
          // cycle still counts as a success.
          if (bus.dct_output_enable) begin
            state    <= DONE;
            blk_done <= grant_oh;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= ERR;
            blk_err <= grant_oh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE, ERR: begin
          state      <= IDLE;
          busy       <= 1'b0;
          last_grant <= grant_id;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The pixel path is a plain mux. The owner's buffer drives its next pixel
  // in the same cycle that its ready strobe is high.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) pix[i] = bus.src_data[8*i +: 8];
  end

  assign bus.dct_data_in = (state == FEED) ? pix[grant_id] : 8'd0;
  assign bus.src_ready   = src_ready;
  assign bus.blk_done    = blk_done;
  assign bus.blk_err     = blk_err;
  assign bus.dct_rst     = dct_rst;
  assign bus.dct_enable  = dct_enable;
  assign bus.busy        = busy;
  assign bus.grant_id    = grant_id;

endmodule
